muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide execution unit for the next-generation pipeline, sitting beside the ALU in the EX stage. Accepts one operation per start pulse and computes all eight M-extension operations (funct3-encoded) over a parametrised operand width with a radix-2, one-bit-per-cycle datapath. Holds the pipeline through `busy`, returns a registered result with a one-cycle `done` pulse, and supports synchronous flush on branch redirect.

## Interface
- XLEN, 32, operand/result width (≥ 8, even)
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  asynchronous, active-low reset
- start  input  1  request; sampled on rising edge
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  input  XLEN  rs1 operand (multiplicand / dividend)
- op_b  input  XLEN  rs2 operand (multiplier / divisor)
- flush  input  1  abort in-flight operation (pipeline redirect)
- busy  output  1  high while iterating; EX stage stalls on it
- done  output  1  one-cycle pulse; result valid
- result  output  XLEN  registered result, held until next completion

## Operation
- States: IDLE, CALC, DONE. Reset → IDLE, busy=0, done=0, result=0, counter=0.
- Accept: start=1, flush=0, state ∈ {IDLE, DONE} at an edge → latch funct3, |op_a|, |op_b| (abs taken only for signed operands), result sign flags; counter=0; → CALC. start while in CALC is ignored (not queued).
- Signedness: MUL/MULH/DIV/REM both signed; MULHSU op_a signed, op_b unsigned; MULHU/DIVU/REMU unsigned.
- Multiply: 2·XLEN shift-add product of magnitudes, one multiplier bit per cycle; negate 2·XLEN product if signs differ; MUL returns low XLEN, MULH* high XLEN.
- Divide: restoring shift-subtract on magnitudes, one quotient bit per cycle; quotient negated if signs differ, remainder takes dividend sign.
- Special cases (detected at accept, skip CALC, → DONE directly): divisor=0 → DIV/DIVU result all-ones, REM/REMU result = op_a; signed overflow (op_a = −2^(XLEN−1), op_b = −1) → DIV result op_a, REM result 0.
- CALC: counter increments each edge; on edge with counter = XLEN−1, sign fix-up applied, result registered, → DONE.
- DONE: done=1 for exactly one cycle; next edge → IDLE unless a new start is accepted (back-to-back allowed).
- flush=1 at any edge: → IDLE, done=0 next cycle, result unchanged; flush overrides start on the same edge.
- Async reset mid-operation: immediate return to reset values, no done pulse.

## Timing
- Iterative ops: start accepted at edge E0; busy=1 from E0 through E(XLEN); done=1 and result valid in the cycle after E(XLEN) (XLEN cycles after accept).
- Special-case ops: done=1 in the cycle after E0; busy never asserted.
- busy and done never high simultaneously; done never two consecutive cycles for one operation.
- result changes only on the edge that enters DONE or on reset.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- MULDIV_DIV_EN defined: full unit, divide/remainder datapath and special cases as above.
- MULDIV_DIV_EN undefined: divider datapath not compiled; funct3[2]=1 requests complete as special case (done after 1 cycle, busy never asserted) with result=0; multiply behaviour and timing unchanged.

## Test plan
- MUL op_a=7, op_b=0xFFFFFFFD (−3), XLEN=32 → busy 32 cycles, done pulse, result=0xFFFFFFEB.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2.
- DIVU 5/0 → 0xFFFFFFFF with done 1 cycle after accept, busy never high; REM 0x80000000 / 0xFFFFFFFF → 0; DIV same → 0x80000000.
- Start MUL, assert flush after 10 CALC cycles → busy low next cycle, no done pulse, result keeps prior value; immediate new start completes normally. Start during CALC ignored.
- Assert rst low mid-CALC → busy=0, done=0, result=0 without clock edge; without MULDIV_DIV_EN, DIV 100/7 → result 0 after 1 cycle.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit: one product/quotient bit per cycle, busy/done handshake, flush.
// Build option: define MULDIV_DIV_EN to compile the divider; otherwise divide ops complete immediately with result 0.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned     CNT_W    = $clog2(XLEN);
    localparam int unsigned     PW       = 2 * XLEN;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  hi_q, hi_d;
    logic [XLEN-1:0]  lo_q, lo_d;
    logic [XLEN-1:0]  b_q, b_d;
    logic             neg_q, neg_d;
    logic             sel_hi_q, sel_hi_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [XLEN-1:0]  result_q, result_d;
`ifdef MULDIV_DIV_EN
    logic             is_div_q, is_div_d;
    logic             neg_rem_q, neg_rem_d;
    logic [XLEN:0]    div_shift;
    logic [XLEN+1:0]  div_diff;
    logic             div_ge;
`endif

    logic            a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            accept, special;
    logic [XLEN-1:0] special_res;

    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] step_hi, step_lo;
    logic [PW-1:0]   prod, prod_fix;
    logic [XLEN-1:0] fix_res;

    // Operand signedness, magnitudes and immediate-completion cases
    always_comb begin : decode
        a_signed    = (funct3 != F_MULHU) && (funct3 != F_DIVU) && (funct3 != F_REMU);
        b_signed    = a_signed && (funct3 != F_MULHSU);
        a_neg       = a_signed & op_a[XLEN-1];
        b_neg       = b_signed & op_b[XLEN-1];
        a_mag       = a_neg ? (~op_a + XLEN'(1)) : op_a;
        b_mag       = b_neg ? (~op_b + XLEN'(1)) : op_b;
        accept      = start && !flush && (state_q != S_CALC);
        special     = 1'b0;
        special_res = '0;
`ifdef MULDIV_DIV_EN
        if (funct3[2]) begin
            if (op_b == '0) begin
                special     = 1'b1;
                special_res = funct3[1] ? op_a : '1;
            end else if (!funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1)) begin
                special     = 1'b1;
                special_res = funct3[1] ? '0 : op_a;
            end
        end
`else
        special = funct3[2];
`endif
    end

    // One iteration step plus final sign fix-up; hi/lo hold product halves or remainder/quotient
    always_comb begin : datapath
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        step_hi  = mul_sum[XLEN:1];
        step_lo  = {mul_sum[0], lo_q[XLEN-1:1]};
        prod     = {step_hi, step_lo};
        prod_fix = neg_q ? (~prod + PW'(1)) : prod;
        fix_res  = sel_hi_q ? prod_fix[PW-1:XLEN] : prod_fix[XLEN-1:0];
`ifdef MULDIV_DIV_EN
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, b_q};
        div_ge    = !div_diff[XLEN+1];
        if (is_div_q) begin
            step_hi = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            step_lo = {lo_q[XLEN-2:0], div_ge};
            if (sel_hi_q) begin
                fix_res = neg_rem_q ? (~step_hi + XLEN'(1)) : step_hi;
            end else begin
                fix_res = neg_q ? (~step_lo + XLEN'(1)) : step_lo;
            end
        end
`endif
    end

    // Next-state and output logic
    always_comb begin : fsm_next
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        neg_d    = neg_q;
        sel_hi_d = sel_hi_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        result_d = result_q;
`ifdef MULDIV_DIV_EN
        is_div_d  = is_div_q;
        neg_rem_d = neg_rem_q;
`endif
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_CALC: begin
                    hi_d   = step_hi;
                    lo_d   = step_lo;
                    cnt_d  = cnt_q + CNT_W'(1);
                    busy_d = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d  = S_DONE;
                        result_d = fix_res;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = state_q;
            endcase

            if (accept) begin
                cnt_d    = '0;
                hi_d     = '0;
                neg_d    = a_neg ^ b_neg;
                sel_hi_d = funct3[2] ? funct3[1] : (funct3[1:0] != 2'b00);
                if (funct3[2]) begin
                    lo_d = a_mag;
                    b_d  = b_mag;
                end else begin
                    lo_d = b_mag;
                    b_d  = a_mag;
                end
`ifdef MULDIV_DIV_EN
                is_div_d  = funct3[2];
                neg_rem_d = a_neg;
`endif
                if (special) begin
                    state_d  = S_DONE;
                    result_d = special_res;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                end else begin
                    state_d = S_CALC;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            b_q       <= '0;
            neg_q     <= 1'b0;
            sel_hi_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
`ifdef MULDIV_DIV_EN
            is_div_q  <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            b_q       <= b_d;
            neg_q     <= neg_d;
            sel_hi_q  <= sel_hi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
`ifdef MULDIV_DIV_EN
            is_div_q  <= is_div_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: random and directed RV32M ops checked against a plain-arithmetic model.
module tb_muldiv_unit;

    localparam int XLEN = 32;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_acc = 0;
    bit          last_iter = 1'b0;
    logic [31:0] held = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Divide ops that finish without iterating
    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_DIV_EN
        return f[2] && ((b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
`else
        return f[2];
`endif
    endfunction

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
`ifndef MULDIV_DIV_EN
        if (f[2]) return 32'd0;
`endif
        case (f)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * longint'({32'd0, b})); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = 64'(sa / sb);
                return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = 64'(sa % sb);
                return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op (called just after an edge), record expectation, wait until its done cycle
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit poke);
        exp_t e;
        int   lat;
        start  = 1'b1;
        funct3 = f;
        op_a   = a;
        op_b   = b;
        tick();
        start     = 1'b0;
        lat       = is_special(f, a, b) ? 0 : XLEN;
        e.res     = model(f, a, b);
        e.acc     = cyc;
        e.lat     = lat;
        sbq.push_back(e);
        last_acc  = cyc;
        last_iter = (lat != 0);
        for (int i = 1; i <= lat; i++) begin
            if (poke && i == 5) begin
                start  = 1'b1;
                funct3 = 3'($urandom_range(0, 7));
                op_a   = $urandom;
                op_b   = $urandom;
            end
            tick();
            start = 1'b0;
        end
    endtask

    // Monitor: pops the scoreboard on done, otherwise checks busy and result hold
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            chk("busy", 32'(busy), 32'(last_iter && ((cyc - last_acc) < XLEN)));
            if (done) begin
                chk("busy_with_done", 32'(busy), 32'd0);
                chk("done_has_pending_op", 32'(sbq.size() != 0), 32'd1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    chk("result", result, e.res);
                    chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                    held = e.res;
                end
            end else begin
                chk("result_hold", result, held);
            end
        end
    end

    logic [2:0]  df [14] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                             3'd5, 3'd6, 3'd4, 3'd4, 3'd7, 3'd0};
    logic [31:0] da [14] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                             32'd5, 32'h8000_0000, 32'h8000_0000, 32'd100, 32'd5, 32'd0};
    logic [31:0] db [14] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'd2, 32'd2, 32'd7, 32'd7,
                             32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd0, 32'd0};

    initial begin
        rst    = 1'b0;
        start  = 1'b0;
        funct3 = 3'd0;
        op_a   = '0;
        op_b   = '0;
        flush  = 1'b0;
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", result, 32'd0);
        #6 rst = 1'b1;
        tick();

        for (int i = 0; i < 14; i++) issue(df[i], da[i], db[i], 1'b0);
        tick();

        // Start pulses during CALC must be ignored
        issue(3'd1, $urandom, $urandom, 1'b1);
        tick();

        // Flush after ten CALC cycles: no done, result kept
        funct3 = 3'd0;
        op_a   = $urandom;
        op_b   = $urandom;
        start  = 1'b1;
        tick();
        start = 1'b0;
        sbq.push_back('{model(3'd0, op_a, op_b), cyc, XLEN});
        last_acc  = cyc;
        last_iter = 1'b1;
        repeat (10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        sbq.delete();
        last_iter = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_done", 32'(done), 32'd0);
        chk("flush_result", result, held);
        repeat (XLEN + 8) tick();
        issue(3'd0, $urandom, $urandom, 1'b0);
        tick();

        // Flush wins over a simultaneous start
        funct3 = 3'd0;
        op_a   = 32'd3;
        op_b   = 32'd5;
        start  = 1'b1;
        flush  = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b0;
        chk("flush_over_start_busy", 32'(busy), 32'd0);
        repeat (XLEN + 3) tick();

        // Randomised ops, back-to-back and with idle gaps
        repeat (150) begin
            issue(3'($urandom_range(0, 7)), pick(), pick(), ($urandom_range(0, 9) == 0));
            repeat ($urandom_range(0, 2)) tick();
        end
        tick();

        // Asynchronous reset in the middle of CALC
        funct3 = 3'd3;
        op_a   = 32'hFFFF_FFFF;
        op_b   = 32'h1234_5678;
        start  = 1'b1;
        tick();
        start = 1'b0;
        sbq.push_back('{model(3'd3, op_a, op_b), cyc, XLEN});
        last_acc  = cyc;
        last_iter = 1'b1;
        repeat (7) tick();
        #2 rst = 1'b0;
        #1;
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_done", 32'(done), 32'd0);
        chk("midreset_result", result, 32'd0);
        sbq.delete();
        held      = '0;
        last_iter = 1'b0;
        #2 rst = 1'b1;
        tick();
        issue(3'd5, 32'd100, 32'd7, 1'b0);
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0);

        repeat (5) tick();
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
